hs4_bd_sender: RTL

- Clocked transmitter for a 4-phase, return-to-zero, bundled-data handshake into a Muller C-element pipeline.
- Accepts words from synchronous logic over a valid/ready interface and drives req_out plus data_out into the first asynchronous stage.
- Waits on that stage's ack_in through a synchronizer, then returns req_out to zero.
- Sits at the sync-to-async boundary, feeding the Muller pipeline from the clocked domain.

---
 rtl/hs4_bd_sender.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hs4_bd_sender.sv
// Clocked sender for a 4-phase return-to-zero bundled-data handshake into a
// Muller C-element pipeline; ack_in is synchronized before any decision.
module hs4_bd_sender #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SETUP_CYC   = 1,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in,
    output logic              busy,
    output logic [CNT_W-1:0]  tx_count,
    output logic              err_timeout
);

    localparam int SET_W = $clog2(SETUP_CYC + 1);
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    // state   | meaning
    // IDLE    | no transfer, accepts a word when ack_s is low
    // SETUP   | data_out driven, counting bundling delay, req_out low
    // WAIT_HI | req_out high, waiting for ack_s to rise
    // WAIT_LO | req_out low again, waiting for ack_s to return to zero
    typedef enum logic [1:0] {IDLE, SETUP, WAIT_HI, WAIT_LO} state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic               req_q, req_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_s;
    logic               to_tick;

    assign ack_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], ack_in};
        req_d     = req_q;
        data_d    = data_q;
        set_cnt_d = set_cnt_q;
        to_cnt_d  = to_cnt_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        to_tick   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !ack_s) begin
                    data_d    = in_data;
                    set_cnt_d = SET_W'(SETUP_CYC);
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (set_cnt_q == '0) begin
                    req_d    = 1'b1;
                    to_cnt_d = TO_W'(TIMEOUT_CYC);
                    state_d  = WAIT_HI;
                end else begin
                    set_cnt_d = set_cnt_q - SET_W'(1);
                end
            end
            WAIT_HI: begin
                if (ack_s) begin
                    req_d    = 1'b0;
                    to_cnt_d = TO_W'(TIMEOUT_CYC);
                    state_d  = WAIT_LO;
                end else begin
                    to_tick = 1'b1;
                end
            end
            WAIT_LO: begin
                if (!ack_s) begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    to_cnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    to_tick = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Down-counter parks at zero once expired; the flag is sticky and the
        // handshake keeps waiting because req_out may not be withdrawn early.
        if (TIMEOUT_CYC > 0 && to_tick && to_cnt_q != '0) begin
            to_cnt_d = to_cnt_q - TO_W'(1);
            if (to_cnt_q == TO_W'(1)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            req_q     <= 1'b0;
            data_q    <= '0;
            set_cnt_q <= '0;
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            req_q     <= req_d;
            data_q    <= data_d;
            set_cnt_q <= set_cnt_d;
            to_cnt_q  <= to_cnt_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Gated by rst so every output reads low while reset is held.
    assign in_ready    = rst && (state_q == IDLE) && !ack_s;
    assign busy        = (state_q != IDLE);
    assign req_out     = req_q;
    assign data_out    = data_q;
    assign tx_count    = cnt_q;
    assign err_timeout = err_q;

endmodule
